router_mesh_np: RTL and testbench
=================================

// Module: router_mesh_np
// PURPOSE
//  Parametrised 5-port (LOCAL/EAST/WEST/NORTH/SOUTH) single-flit wormhole-free router for MESH_X x MESH_Y mesh.
//  Input FIFO per port, dimension-ordered XY route compute, per-output round-robin switch allocation, registered outputs.
//  Replaces the fixed 3-port border / interior variants: absent ports removed via PORT_MASK. One instance per mesh node.
// PARAMETERS
//  DATA_WIDTH  32      flit width; dst address in flit[XW+YW-1:0], XW=$clog2(MESH_X), YW=$clog2(MESH_Y)
//  FIFO_DEPTH  8       input FIFO entries per port; power of two, >=2
//  MESH_X      4       mesh columns
//  MESH_Y      2       mesh rows
//  ROUTER_X    0       this node column
//  ROUTER_Y    0       this node row
//  PORT_MASK   5'h1F   bit p=1: port p present; absent port inputs ignored, outputs tied 0
// PORTS  (port index p: 0=LOCAL 1=EAST 2=WEST 3=NORTH 4=SOUTH; bus slice p = [p*DATA_WIDTH +: DATA_WIDTH])
//  clk           in   1             clock, single domain
//  rst_n         in   1             asynchronous, active-low reset
//  in_data       in   5*DATA_WIDTH  incoming flits
//  in_valid      in   5             flit present on slice p
//  in_full       out  5             input FIFO p full; upstream must not assert in_valid[p]
//  out_data      out  5*DATA_WIDTH  outgoing flits (registered)
//  out_valid     out  5             out_data slice p holds a flit
//  out_full      in   5             downstream of output p cannot accept
//  route_err     out  1             sticky: a flit was dropped (route to absent port)
// BEHAVIOUR
//  Reset (async assert, sync release): out_data=0, out_valid=0, in_full=0, route_err=0; FIFOs empty; RR pointers=0.
//  Reset mid-operation: all buffered/in-flight flits discarded, nothing replayed after release.
//  Input accept: write when in_valid[p] & !in_full[p] & PORT_MASK[p]; write with in_full high is dropped.
//  in_full[p] = (count_p == FIFO_DEPTH), registered from count; simultaneous read+write when full: write rejected.
//  FIFO is show-ahead; no empty bypass. Simultaneous read+write when not full/empty: count unchanged.
//  Route (combinational on FIFO head): dx=dst[XW-1:0], dy=dst[XW+YW-1:XW].
//   dx>ROUTER_X->EAST; dx<ROUTER_X->WEST; else dy>ROUTER_Y->SOUTH; dy<ROUTER_Y->NORTH; else LOCAL.
//  Head routed to port with PORT_MASK=0 (or dx>=MESH_X / dy>=MESH_Y): popped, discarded, route_err<=1 until reset.
//  Output register p "free" when !out_valid[p] | !out_full[p] (current flit consumed this cycle).
//  Allocation per output p: requesters = inputs whose head routes to p; if free, grant one by round-robin,
//   priority starts at (ptr_p+1) mod 5 (after reset priority starts at index 0); ptr_p <= granted index on grant only.
//  Grant: pop winner FIFO, load out_data[p] with flit, out_valid[p]<=1 same edge. Free & no grant: out_valid[p]<=0.
//  Not free: out_data/out_valid hold unchanged (no data change while out_full high).
//  Each input requests one output per cycle, so no input-side conflict; one flit per output per cycle max.
//  Zero-load latency: flit on in_valid in cycle c -> out_valid in cycle c+2. Throughput 1 flit/cycle/output.
//  U-turn (output == arrival port) permitted only for LOCAL->LOCAL (dst == own address).
//  Flit order preserved per (input, output) pair; no loss, no duplication under any out_full pattern.
// STRUCTURE
//  Shared header router_np_defs.v (`define): PORT_LOCAL/EAST/WEST/NORTH/SOUTH indices, NPORT=5, port-slice macro.
//  Sub-module router_rr_arbiter: 5-bit req, en, grant one-hot, rotating ptr register; instanced once per output.
//  Input FIFOs, route compute, output registers inline via generate over p.
// TESTING
//  T1 ROUTER=(1,0): LOCAL flit dst=3'b111 at cycle c -> out_valid[EAST]=1 at c+2, data bit-exact; others 0.
//  T2 L,W,N,S heads all to EAST same cycle, out_full=0 -> EAST emits L,W,N,S on 4 consecutive cycles.
//  T3 out_full[EAST]=1, 9 flits WEST->EAST -> in_full[WEST]=1 after 9th; release -> 9 flits in order, none lost.
//  T4 PORT_MASK=5'b10101, flit routed EAST -> dropped, route_err=1 sticky; concurrent LOCAL traffic unaffected.
//  T5 rst_n low mid-stream with full FIFOs -> outputs 0 immediately; after release no stale flit emitted.
//  T6 random all-port traffic, random out_full -> scoreboard: per-pair order, exact delivery count, no starvation.

Source files
------------

// File: rtl/router_mesh_np_pkg.sv
// Shared types and helpers for the parametrised 5-port XY mesh router.
package router_mesh_np_pkg;

  localparam int unsigned NPORT = 5;
  localparam int unsigned PW    = 3;

  typedef enum logic [PW-1:0] {
    PORT_LOCAL = 3'd0,
    PORT_EAST  = 3'd1,
    PORT_WEST  = 3'd2,
    PORT_NORTH = 3'd3,
    PORT_SOUTH = 3'd4
  } port_e;

  typedef struct packed {
    logic  vld;
    logic  drop;
    port_e dir;
  } route_t;

  // Dimension-ordered routing: resolve X first, then Y.
  function automatic port_e xy_route(input int unsigned dx, input int unsigned dy,
                                     input int unsigned rx, input int unsigned ry);
    if (dx > rx)      return PORT_EAST;
    else if (dx < rx) return PORT_WEST;
    else if (dy > ry) return PORT_SOUTH;
    else if (dy < ry) return PORT_NORTH;
    else              return PORT_LOCAL;
  endfunction

endpackage

// File: rtl/router_mesh_np_rr_arbiter.sv
// Round-robin arbiter for one router output; search starts after the last winner.
module router_mesh_np_rr_arbiter
  import router_mesh_np_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NPORT-1:0] req_i,
  input  logic             en_i,
  output logic [NPORT-1:0] grant_c
);

  logic [PW-1:0] ptr_q, ptr_d;
  logic          primed_q;

  // Until the first grant the search starts at index 0.
  always_comb begin
    int unsigned start;
    logic [PW-1:0] idx;
    logic found;
    grant_c = '0;
    ptr_d   = ptr_q;
    found   = 1'b0;
    idx     = '0;
    start   = primed_q ? (32'(ptr_q) + 32'd1) % NPORT : 32'd0;
    for (int unsigned k = 0; k < NPORT; k++) begin
      idx = PW'((start + k) % NPORT);
      if (en_i && !found && req_i[idx]) begin
        grant_c[idx] = 1'b1;
        ptr_d        = idx;
        found        = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      primed_q <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      primed_q <= primed_q | (|grant_c);
    end
  end

endmodule

// File: rtl/router_mesh_np.sv
// Single-flit XY mesh router: per-input show-ahead FIFO, per-output RR allocation,
// registered outputs. Ports absent in PORT_MASK are ignored on input and idle on output.
module router_mesh_np
  import router_mesh_np_pkg::*;
#(
  parameter int unsigned      DATA_WIDTH = 32,
  parameter int unsigned      FIFO_DEPTH = 8,
  parameter int unsigned      MESH_X     = 4,
  parameter int unsigned      MESH_Y     = 2,
  parameter int unsigned      ROUTER_X   = 0,
  parameter int unsigned      ROUTER_Y   = 0,
  parameter logic [NPORT-1:0] PORT_MASK  = 5'h1F
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NPORT*DATA_WIDTH-1:0] in_data,
  input  logic [NPORT-1:0]            in_valid,
  output logic [NPORT-1:0]            in_full,
  output logic [NPORT*DATA_WIDTH-1:0] out_data,
  output logic [NPORT-1:0]            out_valid,
  input  logic [NPORT-1:0]            out_full,
  output logic                        route_err
);

  localparam int unsigned XW = (MESH_X > 1) ? $clog2(MESH_X) : 1;
  localparam int unsigned YW = (MESH_Y > 1) ? $clog2(MESH_Y) : 1;
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  route_t                route_c [NPORT];
  logic [DATA_WIDTH-1:0] head_c  [NPORT];
  logic [NPORT-1:0]      gnt_c   [NPORT];  // [output][input]
  logic [NPORT-1:0]      drop_c;
  logic                  route_err_q;

  for (genvar p = 0; p < NPORT; p++) begin : g_in
    localparam bit IS_LOCAL = (p == 0);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, push_c, pop_c;
    logic [XW-1:0]         dx_c;
    logic [YW-1:0]         dy_c;
    route_t                rt_c;

    assign push_c = in_valid[p] & ~full_q & PORT_MASK[p];
    assign head_c[p] = mem_q[rd_ptr_q];
    assign dx_c = head_c[p][XW-1:0];
    assign dy_c = head_c[p][XW+YW-1:XW];

    // Unreachable, out-of-mesh or non-local U-turn destinations are discarded.
    always_comb begin
      rt_c.vld  = (count_q != '0);
      rt_c.dir  = xy_route(32'(dx_c), 32'(dy_c), ROUTER_X, ROUTER_Y);
      rt_c.drop = (32'(dx_c) >= MESH_X) | (32'(dy_c) >= MESH_Y) | ~PORT_MASK[rt_c.dir]
                | ((rt_c.dir == port_e'(PW'(p))) & ~IS_LOCAL);
    end

    assign route_c[p] = rt_c;
    assign drop_c[p]  = rt_c.vld & rt_c.drop;

    always_comb begin
      pop_c = drop_c[p];
      for (int unsigned o = 0; o < NPORT; o++) pop_c = pop_c | gnt_c[o][p];
    end

    assign count_d = count_q + CW'(push_c) - CW'(pop_c);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        full_q   <= 1'b0;
      end else begin
        count_q <= count_d;
        full_q  <= (count_d == CW'(FIFO_DEPTH));
        if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (push_c) mem_q[wr_ptr_q] <= in_data[p*DATA_WIDTH +: DATA_WIDTH];
    end

    assign in_full[p] = full_q;
  end

  for (genvar o = 0; o < NPORT; o++) begin : g_out
    logic [NPORT-1:0]      req_c;
    logic                  free_c, en_c;
    logic [DATA_WIDTH-1:0] win_data_c;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;

    always_comb begin
      req_c = '0;
      for (int unsigned i = 0; i < NPORT; i++) begin
        req_c[i] = route_c[i].vld & ~route_c[i].drop & (route_c[i].dir == port_e'(PW'(o)));
      end
    end

    // Register may be reloaded when empty or when its flit leaves this cycle.
    assign free_c = ~valid_q | ~out_full[o];
    assign en_c   = free_c & PORT_MASK[o];

    router_mesh_np_rr_arbiter u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req_i   (req_c),
      .en_i    (en_c),
      .grant_c (gnt_c[o])
    );

    always_comb begin
      win_data_c = '0;
      for (int unsigned i = 0; i < NPORT; i++) begin
        if (gnt_c[o][i]) win_data_c = head_c[i];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else if (free_c) begin
        valid_q <= |gnt_c[o];
        if (|gnt_c[o]) data_q <= win_data_c;
      end
    end

    assign out_valid[o]                          = valid_q;
    assign out_data[o*DATA_WIDTH +: DATA_WIDTH] = data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       route_err_q <= 1'b0;
    else if (|drop_c) route_err_q <= 1'b1;
  end

  assign route_err = route_err_q;

endmodule

// File: tb/tb_router_mesh_np.sv
// Bench for router_mesh_np: directed latency/arbitration/backpressure/mask/reset steps,
// then random traffic checked against a per-(input,output) queue model.
module tb_router_mesh_np;

  localparam int DW = 32;
  localparam int NP = 5;
  localparam int RX = 1;
  localparam int RY = 0;
  localparam logic [4:0] MASK_A = 5'h1F;
  localparam logic [4:0] MASK_B = 5'b10101;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NP*DW-1:0] a_in_data, a_out_data, b_in_data, b_out_data;
  logic [NP-1:0]    a_in_valid, a_in_full, a_out_valid, a_out_full;
  logic [NP-1:0]    b_in_valid, b_in_full, b_out_valid, b_out_full;
  logic             a_route_err, b_route_err;

  router_mesh_np #(.DATA_WIDTH(DW), .FIFO_DEPTH(8), .MESH_X(4), .MESH_Y(2),
                   .ROUTER_X(RX), .ROUTER_Y(RY), .PORT_MASK(MASK_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_full(a_in_full), .out_data(a_out_data), .out_valid(a_out_valid),
    .out_full(a_out_full), .route_err(a_route_err));

  router_mesh_np #(.DATA_WIDTH(DW), .FIFO_DEPTH(8), .MESH_X(4), .MESH_Y(2),
                   .ROUTER_X(RX), .ROUTER_Y(RY), .PORT_MASK(MASK_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_full(b_in_full), .out_data(b_out_data), .out_valid(b_out_valid),
    .out_full(b_out_full), .route_err(b_route_err));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [31:0] exp_q [25][$];
  int          acc_q [25][$];
  int n_acc, n_drop, n_del, max_lat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    a_in_data = '0; a_in_valid = '0; a_out_full = '0;
    b_in_data = '0; b_in_valid = '0; b_out_full = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  function automatic logic [31:0] a_slice(input int p);
    return a_out_data[p*DW +: DW];
  endfunction

  function automatic logic [31:0] b_slice(input int p);
    return b_out_data[p*DW +: DW];
  endfunction

  task automatic drive_a(input int p, input logic [31:0] d);
    a_in_data[p*DW +: DW] = d;
    a_in_valid[p] = 1'b1;
  endtask

  task automatic drive_b(input int p, input logic [31:0] d);
    b_in_data[p*DW +: DW] = d;
    b_in_valid[p] = 1'b1;
  endtask

  // Flit layout used by the bench: {src[2:0], seq[12:0], random[12:0], dst[2:0]}
  function automatic logic [31:0] mk(input int src, input int seq, input logic [2:0] dst);
    logic [12:0] r;
    r = 13'($urandom);
    return {3'(src), 13'(seq), r, dst};
  endfunction

  // Expected output for a flit at this node (x=1,y=0); -1 means the flit is discarded.
  function automatic int exp_port(input int src, input logic [2:0] dst, input logic [4:0] mask);
    int dx, dy, o;
    dx = int'(dst[1:0]);
    dy = int'(dst[2]);
    if (dx > RX)      o = 1;
    else if (dx < RX) o = 2;
    else if (dy > RY) o = 4;
    else if (dy < RY) o = 3;
    else              o = 0;
    if (!mask[o] || (o == src && src != 0)) return -1;
    return o;
  endfunction

  task automatic model_push(input int p, input logic [31:0] d);
    int o;
    o = exp_port(p, d[2:0], MASK_A);
    if (o < 0) n_drop++;
    else begin
      exp_q[p*5+o].push_back(d);
      acc_q[p*5+o].push_back(cyc);
      n_acc++;
    end
  endtask

  task automatic consume(input int o);
    logic [31:0] d;
    logic [31:0] e;
    int src, lat;
    d = a_slice(o);
    src = int'(d[31:29]);
    n_del++;
    check("t6_src_range", 32'(src < NP), 32'd1);
    if (src < NP) begin
      check("t6_flit_expected", 32'(exp_q[src*5+o].size() != 0), 32'd1);
      if (exp_q[src*5+o].size() != 0) begin
        e = exp_q[src*5+o].pop_front();
        lat = cyc - acc_q[src*5+o].pop_front();
        if (lat > max_lat) max_lat = lat;
        check("t6_order", d, e);
      end
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < 25; i++) s += exp_q[i].size();
    return s;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] f, fw, fl2;
    logic [31:0] fl [4];
    logic [31:0] t3f [9];
    int got, nvalid;

    // Reset state
    idle_inputs();
    rst_n = 1'b0;
    step(); step();
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_in_full", 32'(a_in_full), 32'd0);
    check("rst_route_err", 32'(a_route_err), 32'd0);
    for (int p = 0; p < NP; p++) check("rst_out_data", a_slice(p), 32'd0);
    check("rst_b_out_valid", 32'(b_out_valid), 32'd0);
    rst_n = 1'b1;
    step();

    // T1: zero-load latency LOCAL -> EAST
    f = 32'hC0DE_F00F;
    drive_a(0, f);
    step();
    a_in_valid = '0;
    check("t1_c1_no_valid", 32'(a_out_valid), 32'd0);
    step();
    check("t1_c2_valid", 32'(a_out_valid), 32'b00010);
    check("t1_c2_data", a_slice(1), f);
    step();
    check("t1_c3_idle", 32'(a_out_valid), 32'd0);

    // T2: four inputs contend for EAST after reset
    do_reset();
    fl[0] = mk(0, 1, 3'b011);
    fl[1] = mk(2, 2, 3'b010);
    fl[2] = mk(3, 3, 3'b111);
    fl[3] = mk(4, 4, 3'b110);
    drive_a(0, fl[0]); drive_a(2, fl[1]); drive_a(3, fl[2]); drive_a(4, fl[3]);
    step();
    a_in_valid = '0;
    step();
    for (int k = 0; k < 4; k++) begin
      check("t2_valid", 32'(a_out_valid), 32'b00010);
      check("t2_data", a_slice(1), fl[k]);
      step();
    end
    check("t2_done", 32'(a_out_valid), 32'd0);

    // T3: EAST blocked, WEST FIFO fills, overflow write dropped, release drains in order
    do_reset();
    a_out_full[1] = 1'b1;
    for (int k = 0; k < 9; k++) begin
      t3f[k] = mk(2, k, 3'b011);
      drive_a(2, t3f[k]);
      if (k == 8) check("t3_not_full_before_9th", 32'(a_in_full[2]), 32'd0);
      step();
    end
    a_in_valid = '0;
    check("t3_full", 32'(a_in_full[2]), 32'd1);
    check("t3_held_valid", 32'(a_out_valid), 32'b00010);
    drive_a(2, mk(2, 99, 3'b011));
    step();
    a_in_valid = '0;
    step(); step();
    check("t3_hold_data", a_slice(1), t3f[0]);
    check("t3_still_full", 32'(a_in_full[2]), 32'd1);
    a_out_full[1] = 1'b0;
    got = 0;
    for (int c = 0; c < 30; c++) begin
      if (a_out_valid[1] && !a_out_full[1]) begin
        if (got < 9) check("t3_order", a_slice(1), t3f[got]);
        got++;
      end
      step();
    end
    check("t3_count", 32'(got), 32'd9);
    check("t3_not_full_after", 32'(a_in_full[2]), 32'd0);

    // T4: masked router, flit routed to absent EAST is dropped; other traffic flows
    check("t4_err_before", 32'(b_route_err), 32'd0);
    fw = mk(2, 5, 3'b001);
    drive_b(0, mk(0, 6, 3'b011));
    drive_b(2, fw);
    step();
    b_in_valid = '0;
    fl2 = mk(0, 7, 3'b001);
    drive_b(0, fl2);
    step();
    b_in_valid = '0;
    check("t4_err_set", 32'(b_route_err), 32'd1);
    check("t4_local_valid", 32'(b_out_valid), 32'b00001);
    check("t4_local_data_west", b_slice(0), fw);
    step();
    check("t4_uturn_valid", 32'(b_out_valid), 32'b00001);
    check("t4_uturn_data", b_slice(0), fl2);
    for (int c = 0; c < 5; c++) step();
    check("t4_err_sticky", 32'(b_route_err), 32'd1);
    check("t4_idle", 32'(b_out_valid), 32'd0);
    check("t4_east_tied", b_slice(1), 32'd0);

    // T5: reset with full FIFOs
    do_reset();
    a_out_full = '1;
    for (int k = 0; k < 12; k++) begin
      for (int p = 0; p < NP; p++) begin
        if (!a_in_full[p]) drive_a(p, mk(p, k, 3'b001));
        else a_in_valid[p] = 1'b0;
      end
      step();
    end
    a_in_valid = '0;
    check("t5_all_full", 32'(a_in_full), 32'h1F);
    check("t5_local_held", 32'(a_out_valid), 32'b00001);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_valid", 32'(a_out_valid), 32'd0);
    check("t5_async_full", 32'(a_in_full), 32'd0);
    check("t5_async_data", a_slice(0), 32'd0);
    step(); step();
    rst_n = 1'b1;
    a_out_full = '0;
    nvalid = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (a_out_valid != '0) nvalid++;
    end
    check("t5_no_stale", 32'(nvalid), 32'd0);

    // T6: random traffic and backpressure against the queue model
    do_reset();
    n_acc = 0; n_drop = 0; n_del = 0; max_lat = 0;
    begin
      int seq [NP];
      for (int p = 0; p < NP; p++) seq[p] = 0;
      for (int c = 0; c < 3000; c++) begin
        for (int o = 0; o < NP; o++) a_out_full[o] = ($urandom_range(0, 3) == 0);
        for (int o = 0; o < NP; o++) if (a_out_valid[o] && !a_out_full[o]) consume(o);
        for (int p = 0; p < NP; p++) begin
          if (!a_in_full[p] && $urandom_range(0, 1) == 1) begin
            f = mk(p, seq[p], 3'($urandom));
            seq[p]++;
            drive_a(p, f);
            model_push(p, f);
          end else a_in_valid[p] = 1'b0;
        end
        step();
      end
    end
    a_in_valid = '0;
    a_out_full = '0;
    for (int c = 0; c < 300; c++) begin
      for (int o = 0; o < NP; o++) if (a_out_valid[o]) consume(o);
      step();
      if (pending() == 0) break;
    end
    check("t6_pending_zero", 32'(pending()), 32'd0);
    step();
    check("t6_idle_after_drain", 32'(a_out_valid), 32'd0);
    check("t6_delivered", 32'(n_del), 32'(n_acc));
    check("t6_route_err", 32'(a_route_err), 32'(n_drop > 0));
    check("t6_latency_bound", 32'(max_lat < 1000), 32'd1);
    check("t6_fifos_empty", 32'(a_in_full), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
